operand_sequencer: RTL and testbench

- Control stage directly upstream of the dual-bank operand memory (Ram1 = multiplicands, Ram2 = multipliers, 2**ADDR_WIDTH entries each, one shared address, combinational read).
- Takes a serial word stream of operand pairs and writes each pair into both banks at the same address.
- Then replays the stored pairs, in address order, to the radix-8 Booth multiplier core over a valid/ready handshake.

---
 rtl/operand_sequencer_if.sv | 31 +++
 rtl/operand_sequencer.sv | 154 +++++++++++++++
 tb/tb_operand_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_sequencer_if.sv
// Operand stream, memory port and Booth-core handshake bundle for operand_sequencer.
// The master modport is the sequencer; the slave modport is its surrounding logic.
interface operand_sequencer_if #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] In_Data;
  logic                  In_Valid;
  logic                  In_Ready;
  logic                  In_Last;
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic [DATA_WIDTH-1:0] Mem_Data;
  logic                  Mem_W_En;
  logic                  Mem_M_Sel;
  logic [DATA_WIDTH-1:0] Mem_Data1;
  logic [DATA_WIDTH-1:0] Mem_Data2;
  logic [DATA_WIDTH-1:0] Op_A;
  logic [DATA_WIDTH-1:0] Op_B;
  logic                  Op_Valid;
  logic                  Op_Ready;

  modport master (
    input  In_Data, In_Valid, In_Last, Mem_Data1, Mem_Data2, Op_Ready,
    output In_Ready, Mem_Addr, Mem_Data, Mem_W_En, Mem_M_Sel, Op_A, Op_B, Op_Valid
  );

  modport slave (
    output In_Data, In_Valid, In_Last, Mem_Data1, Mem_Data2, Op_Ready,
    input  In_Ready, Mem_Addr, Mem_Data, Mem_W_En, Mem_M_Sel, Op_A, Op_B, Op_Valid
  );
endinterface

// File: rtl/operand_sequencer.sv
// Loads A/B operand pairs into the dual-bank operand memory, then replays them
// in address order to the Booth multiplier over a valid/ready handshake.
module operand_sequencer #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  operand_sequencer_if.master   bus,
  output logic [ADDR_WIDTH:0]   Pair_Count,
  output logic                  Busy,
  output logic                  Done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WR_PTR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] WR_PTR_INC = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_INC    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH:0]   rd_ptr_r;
  logic [ADDR_WIDTH:0]   pair_count_r;
  logic [DATA_WIDTH-1:0] op_a_r;
  logic [DATA_WIDTH-1:0] op_b_r;
  logic                  op_valid_r;
  logic                  start_s;
  logic                  wr_b_s;
  logic                  op_load_s;
  logic                  op_drain_s;

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus combinational memory/stream controls.
  always_comb begin
    state_nxt_s   = state_r;
    start_s       = 1'b0;
    wr_b_s        = 1'b0;
    op_load_s     = 1'b0;
    op_drain_s    = 1'b0;
    bus.In_Ready  = 1'b0;
    bus.Mem_Addr  = {ADDR_WIDTH{1'b0}};
    bus.Mem_Data  = {DATA_WIDTH{1'b0}};
    bus.Mem_W_En  = 1'b0;
    bus.Mem_M_Sel = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          start_s     = 1'b1;
          state_nxt_s = ST_LOAD_A;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD_A: begin
        bus.In_Ready = 1'b1;
        bus.Mem_W_En = bus.In_Valid;
        bus.Mem_Data = bus.In_Data;
        bus.Mem_Addr = wr_ptr_r;
        if (bus.In_Valid) begin
          state_nxt_s = ST_LOAD_B;
        end else begin
          state_nxt_s = ST_LOAD_A;
        end
      end
      ST_LOAD_B: begin
        bus.In_Ready  = 1'b1;
        bus.Mem_W_En  = bus.In_Valid;
        bus.Mem_Data  = bus.In_Data;
        bus.Mem_Addr  = wr_ptr_r;
        bus.Mem_M_Sel = 1'b1;
        if (bus.In_Valid) begin
          wr_b_s = 1'b1;
          // A full memory ends the load phase even without In_Last.
          if (bus.In_Last || (wr_ptr_r == WR_PTR_MAX)) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_LOAD_A;
          end
        end else begin
          state_nxt_s = ST_LOAD_B;
        end
      end
      ST_RUN: begin
        bus.Mem_Addr = rd_ptr_r[ADDR_WIDTH-1:0];
        if ((!op_valid_r || bus.Op_Ready) && (rd_ptr_r < pair_count_r)) begin
          op_load_s   = 1'b1;
          state_nxt_s = ST_RUN;
        end else if (op_valid_r && bus.Op_Ready && (rd_ptr_r == pair_count_r)) begin
          op_drain_s  = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Pointers, pair count and the registered operand output stage.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r     <= {(ADDR_WIDTH+1){1'b0}};
      pair_count_r <= {(ADDR_WIDTH+1){1'b0}};
      op_a_r       <= {DATA_WIDTH{1'b0}};
      op_b_r       <= {DATA_WIDTH{1'b0}};
      op_valid_r   <= 1'b0;
    end else if (start_s) begin
      wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r     <= {(ADDR_WIDTH+1){1'b0}};
      pair_count_r <= {(ADDR_WIDTH+1){1'b0}};
    end else if (wr_b_s) begin
      wr_ptr_r     <= wr_ptr_r + WR_PTR_INC;
      pair_count_r <= pair_count_r + CNT_INC;
    end else if (op_load_s) begin
      op_a_r     <= bus.Mem_Data1;
      op_b_r     <= bus.Mem_Data2;
      op_valid_r <= 1'b1;
      rd_ptr_r   <= rd_ptr_r + CNT_INC;
    end else if (op_drain_s) begin
      op_valid_r <= 1'b0;
    end
  end

  assign bus.Op_A     = op_a_r;
  assign bus.Op_B     = op_b_r;
  assign bus.Op_Valid = op_valid_r;
  assign Pair_Count   = pair_count_r;
  assign Busy         = (state_r != ST_IDLE);
  assign Done         = (state_r == ST_DONE);

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: directed operand streams feed an
// expected-pair queue that a negedge monitor drains on every Booth handshake.
module tb_operand_sequencer;
  localparam int DW = 9;
  localparam int AW = 4;

  logic          Clk   = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Start = 1'b0;
  logic [AW:0]   Pair_Count;
  logic          Busy;
  logic          Done;

  operand_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  operand_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Start      (Start),
    .bus        (bus),
    .Pair_Count (Pair_Count),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clk = ~Clk;

  logic [DW-1:0]   ram1 [0:(1<<AW)-1];
  logic [DW-1:0]   ram2 [0:(1<<AW)-1];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              hs_count = 0;
  int              wr_count = 0;
  logic [2*DW-1:0] exp_q [$];

  // Dual-bank memory model: synchronous write, combinational read.
  always @(posedge Clk) begin
    if (bus.Mem_W_En) begin
      if (bus.Mem_M_Sel) ram2[bus.Mem_Addr] <= bus.Mem_Data;
      else               ram1[bus.Mem_Addr] <= bus.Mem_Data;
      wr_count <= wr_count + 1;
    end
  end
  assign bus.Mem_Data1 = ram1[bus.Mem_Addr];
  assign bus.Mem_Data2 = ram2[bus.Mem_Addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every handshake seen before the accepting edge pops one expected pair.
  always @(negedge Clk) begin
    logic [2*DW-1:0] e;
    if (Rst_n && bus.Op_Valid && bus.Op_Ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL op_unexpected: got A=%0d B=%0d, expected no operands", bus.Op_A, bus.Op_B);
      end else begin
        e = exp_q.pop_front();
        check("op_pair", 32'({bus.Op_A, bus.Op_B}), 32'(e));
        hs_count++;
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] d, input logic last);
    bit ok = 1'b0;
    bus.In_Data  = d;
    bus.In_Valid = 1'b1;
    bus.In_Last  = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus.In_Ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_accept: word %0d not accepted, expected In_Ready within 20 cycles", d);
    end
    @(posedge Clk); #1;
    bus.In_Valid = 1'b0;
    bus.In_Last  = 1'b0;
  endtask

  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
    exp_q.push_back({a, b});
    send_word(a, 1'b0);
    send_word(b, last);
  endtask

  task automatic start_session();
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cnt);
    bit found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Done) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(found), 32'd1);
    check({name, "_pair_count"}, 32'(Pair_Count), 32'(exp_cnt));
    @(negedge Clk);
    check({name, "_done_pulse"}, 32'(Done), 32'd0);
    check({name, "_idle"}, 32'(Busy), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int wr0;
    bus.In_Data  = '0;
    bus.In_Valid = 1'b0;
    bus.In_Last  = 1'b0;
    bus.Op_Ready = 1'b0;

    // Reset state before any clock edge.
    #2;
    check("rst_op_valid", 32'(bus.Op_Valid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_pair_count", 32'(Pair_Count), 32'd0);
    check("rst_w_en", 32'(bus.Mem_W_En), 32'd0);
    check("rst_in_ready", 32'(bus.In_Ready), 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Three pairs, free-running consumer, with latency and Done timing.
    bus.Op_Ready = 1'b1;
    start_session();
    send_pair(9'd5, 9'd3, 1'b0);
    send_pair(9'd511, 9'd2, 1'b0);
    send_pair(9'd0, 9'd7, 1'b1);
    check("t1_ram1_0", 32'(ram1[0]), 32'd5);
    check("t1_ram1_1", 32'(ram1[1]), 32'd511);
    check("t1_ram1_2", 32'(ram1[2]), 32'd0);
    check("t1_ram2_0", 32'(ram2[0]), 32'd3);
    check("t1_ram2_1", 32'(ram2[1]), 32'd2);
    check("t1_ram2_2", 32'(ram2[2]), 32'd7);
    check("t1_run_busy", 32'(Busy), 32'd1);
    @(negedge Clk);
    check("t1_valid_first_cycle", 32'(bus.Op_Valid), 32'd0);
    @(negedge Clk);
    check("t1_valid_second_cycle", 32'(bus.Op_Valid), 32'd1);
    check("t1_first_a", 32'(bus.Op_A), 32'd5);
    @(negedge Clk);
    check("t1_done_early", 32'(Done), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    check("t1_done_after_last", 32'(Done), 32'd1);
    check("t1_pair_count", 32'(Pair_Count), 32'd3);
    @(negedge Clk);
    check("t1_done_pulse", 32'(Done), 32'd0);
    check("t1_handshakes", 32'(hs_count), 32'd3);
    @(posedge Clk); #1;

    // Backpressure: first pair held while the consumer stalls.
    bus.Op_Ready = 1'b0;
    start_session();
    send_pair(9'd100, 9'd200, 1'b0);
    send_pair(9'd37, 9'd400, 1'b1);
    @(negedge Clk);
    @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_valid", 32'(bus.Op_Valid), 32'd1);
      check("t2_hold_a", 32'(bus.Op_A), 32'd100);
      check("t2_hold_b", 32'(bus.Op_B), 32'd200);
      check("t2_hold_rd_ptr", 32'(bus.Mem_Addr), 32'd1);
      check("t2_hold_done", 32'(Done), 32'd0);
      @(negedge Clk);
    end
    @(posedge Clk); #1;
    bus.Op_Ready = 1'b1;
    wait_done("t2", 2);

    // Full memory: sixteen pairs without In_Last.
    bus.Op_Ready = 1'b1;
    start_session();
    for (int i = 0; i < 16; i++) begin
      send_pair(9'(i * 3 + 1), 9'(511 - i), 1'b0);
    end
    check("t3_busy", 32'(Busy), 32'd1);
    check("t3_pair_count", 32'(Pair_Count), 32'd16);
    bus.In_Data  = 9'd99;
    bus.In_Valid = 1'b1;
    @(negedge Clk);
    check("t3_extra_in_ready", 32'(bus.In_Ready), 32'd0);
    check("t3_extra_w_en", 32'(bus.Mem_W_En), 32'd0);
    @(posedge Clk); #1;
    bus.In_Valid = 1'b0;
    wait_done("t3", 16);
    check("t3_ram1_15", 32'(ram1[15]), 32'd46);
    check("t3_ram2_15", 32'(ram2[15]), 32'd496);

    // Gaps in the stream and Start pulses while busy.
    bus.Op_Ready = 1'b0;
    start_session();
    wr0 = wr_count;
    exp_q.push_back({9'd20, 9'd30});
    send_word(9'd20, 1'b0);
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("t4_loadb_busy", 32'(Busy), 32'd1);
    check("t4_loadb_sel", 32'(bus.Mem_M_Sel), 32'd1);
    check("t4_loadb_count", 32'(Pair_Count), 32'd0);
    @(posedge Clk); #1;
    send_word(9'd30, 1'b0);
    @(posedge Clk); #1;
    exp_q.push_back({9'd40, 9'd50});
    send_word(9'd40, 1'b0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    send_word(9'd50, 1'b1);
    check("t4_write_count", 32'(wr_count - wr0), 32'd4);
    check("t4_ram1_1", 32'(ram1[1]), 32'd40);
    check("t4_ram2_1", 32'(ram2[1]), 32'd50);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("t4_run_count", 32'(Pair_Count), 32'd2);
    check("t4_run_valid", 32'(bus.Op_Valid), 32'd1);
    check("t4_run_a", 32'(bus.Op_A), 32'd20);
    check("t4_run_busy", 32'(Busy), 32'd1);
    bus.Op_Ready = 1'b1;
    wait_done("t4", 2);

    // Reset in the middle of a replay, then a fresh session.
    bus.Op_Ready = 1'b1;
    start_session();
    for (int i = 0; i < 5; i++) begin
      send_pair(9'(i + 10), 9'(i + 20), (i == 4));
    end
    hs0 = hs_count;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      if (hs_count - hs0 >= 2) break;
    end
    check("t5_two_accepted", 32'(hs_count - hs0), 32'd2);
    Rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(bus.Op_Valid), 32'd0);
    check("t5_rst_busy", 32'(Busy), 32'd0);
    check("t5_rst_count", 32'(Pair_Count), 32'd0);
    exp_q.delete();
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    start_session();
    send_pair(9'd77, 9'd88, 1'b1);
    check("t5_ram1_0", 32'(ram1[0]), 32'd77);
    check("t5_ram2_0", 32'(ram2[0]), 32'd88);
    wait_done("t5", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
